// File: rtl/zmod_rx_align_pkg.sv
// Shared types and defaults for the Zmod receive word aligner.
package zmod_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    LOCKED,
    FAIL
  } rx_align_state_t;

  localparam int         ZMOD_WORD_W     = 8;
  localparam logic [7:0] ZMOD_TRAIN_WORD = 8'h0F;

endpackage

// File: rtl/zmod_rx_align_slip.sv
// In-fabric bitslip: two-word history plus a registered MSB-first barrel select.
// din to dout latency is 3 cycles.
module zmod_rx_slip
  import zmod_rx_pkg::*;
#(
  parameter int W = ZMOD_WORD_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [W-1:0]         din,
  input  logic [$clog2(W)-1:0] offset,
  output logic [W-1:0]         dout
);

  logic [W-1:0]   r0_q, r1_q, s_q;
  logic [2*W-1:0] cat_sh;
  logic [W-1:0]   s_d;

  // r1 is the older word, so shifting the pair left by offset slides the window later in the bitstream.
  always_comb begin
    cat_sh = {r1_q, r0_q} << offset;
    s_d    = cat_sh[2*W-1 -: W];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r0_q <= '0;
      r1_q <= '0;
      s_q  <= '0;
    end else begin
      r0_q <= din;
      r1_q <= r0_q;
      s_q  <= s_d;
    end
  end

  assign dout = s_q;

endmodule

// File: rtl/zmod_rx_align.sv
// Zmod RX word aligner: hunts for TRAIN by stepping the bitslip offset, then holds lock.
// All status outputs are registered from the next-state decode.
module zmod_rx_align
  import zmod_rx_pkg::*;
#(
  parameter int             W          = ZMOD_WORD_W,
  parameter logic [W-1:0]   TRAIN      = W'(ZMOD_TRAIN_WORD),
  parameter int             MATCH_N    = 4,
  parameter int             SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [W-1:0]         din,
  input  logic                 align_req,
  output logic [W-1:0]         dout,
  output logic                 dvalid,
  output logic                 aligned,
  output logic                 align_fail,
  output logic [$clog2(W)-1:0] offset
);

  localparam int OW = $clog2(W);

  rx_align_state_t state_q, state_d;
  logic [OW-1:0]   offset_q, offset_d;
  logic [OW-1:0]   tries_q, tries_d;
  logic [3:0]      match_cnt_q, match_cnt_d;
  logic [2:0]      settle_cnt_q, settle_cnt_d;
  logic            aligned_q, aligned_d;
  logic            dvalid_q, dvalid_d;
  logic            fail_q, fail_d;
  logic [W-1:0]    s;

  zmod_rx_slip #(.W(W)) u_slip (
    .clk    (clk),
    .rstn   (rstn),
    .din    (din),
    .offset (offset_q),
    .dout   (s)
  );

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    tries_d      = tries_q;
    match_cnt_d  = match_cnt_q;
    settle_cnt_d = settle_cnt_q;
    if (!en) begin
      state_d      = IDLE;
      offset_d     = '0;
      tries_d      = '0;
      match_cnt_d  = '0;
      settle_cnt_d = '0;
    end else if (align_req || state_q == IDLE) begin
      state_d      = SETTLE;
      offset_d     = '0;
      tries_d      = '0;
      match_cnt_d  = '0;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (settle_cnt_q == 3'(SETTLE_CYC - 1)) begin
            state_d      = CHECK;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + 3'd1;
          end
        end
        CHECK: begin
          if (s == TRAIN) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_q == 4'(MATCH_N - 1)) state_d = LOCKED;
          end else if (tries_q == OW'(W - 1)) begin
            state_d = FAIL;
          end else begin
            // Every offset change goes back through SETTLE so the slip pipeline refills first.
            state_d      = SETTLE;
            offset_d     = offset_q + 1'b1;
            tries_d      = tries_q + 1'b1;
            match_cnt_d  = '0;
            settle_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
    aligned_d = (state_d == LOCKED);
    dvalid_d  = (state_d == LOCKED);
    fail_d    = (state_d == FAIL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      offset_q     <= '0;
      tries_q      <= '0;
      match_cnt_q  <= '0;
      settle_cnt_q <= '0;
      aligned_q    <= 1'b0;
      dvalid_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      tries_q      <= tries_d;
      match_cnt_q  <= match_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      aligned_q    <= aligned_d;
      dvalid_q     <= dvalid_d;
      fail_q       <= fail_d;
    end
  end

  assign dout       = s;
  assign dvalid     = dvalid_q;
  assign aligned    = aligned_q;
  assign align_fail = fail_q;
  assign offset     = offset_q;

endmodule

// File: tb/tb_zmod_rx_align.sv
// Directed bench for zmod_rx_align: control checks inline, dout checked by a scoreboard monitor.
module tb_zmod_rx_align;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       align_req = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       dvalid, aligned, align_fail;
  logic [2:0] offset;

  typedef struct {
    int         due;
    logic [7:0] exp;
    bit         dc;
  } sb_t;

  sb_t        sbq[$];
  sb_t        mon_e;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] cur_exp = 8'h00;
  bit         cur_dc = 1'b0;

  zmod_rx_align dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .din        (din),
    .align_req  (align_req),
    .dout       (dout),
    .dvalid     (dvalid),
    .aligned    (aligned),
    .align_fail (align_fail),
    .offset     (offset)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Expected aligned word is due 3 edges after the cycle din was driven.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due < cyc) sbq.delete(0);
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      mon_e = sbq.pop_front();
      if (dvalid === 1'b1 && !mon_e.dc) begin
        n_cmp++;
        if (dout !== mon_e.exp) begin
          n_err++;
          $display("FAIL dout @cyc %0d: got %h want %h", cyc, dout, mon_e.exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    sbq.push_back('{due: cyc + 3, exp: cur_exp, dc: cur_dc});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    en        = 1'b0;
    align_req = 1'b0;
    sbq.delete();
    repeat (2) step();
    rstn = 1'b1;
  endtask

  task automatic wait_aligned(input int maxc, output int n);
    n = 0;
    while (n < maxc && aligned !== 1'b1) begin
      step();
      n++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_dvalid"}, dvalid, 0);
    chk({tag, "_aligned"}, aligned, 0);
    chk({tag, "_align_fail"}, align_fail, 0);
    chk({tag, "_offset"}, offset, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [2:0] last;
    logic [2:0] offs[$];

    // Reset held with live inputs: everything stays zero.
    rstn = 1'b0;
    en   = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      din = 8'($urandom);
      step();
      if (i == 0 || i == 3) chk_all_zero("reset");
    end

    // Aligned stream at offset 0, then payload passthrough while locked.
    do_reset();
    din = 8'h0F; cur_exp = 8'h0F; en = 1'b1;
    wait_aligned(12, lat);
    chk("aligned_lat_le10", lat <= 10, 1);
    chk("aligned_locked", aligned, 1);
    chk("aligned_dvalid", dvalid, 1);
    chk("aligned_offset", offset, 0);
    din = 8'hA7; cur_exp = 8'hA7;
    repeat (4) step();
    din = 8'h0F; cur_exp = 8'h0F;
    repeat (5) step();
    chk("payload_hold_lock", aligned, 1);

    // align_req after two matches must restart the full settle + match count.
    do_reset();
    din = 8'h0F; cur_exp = 8'h0F; en = 1'b1;
    repeat (5) step();
    chk("midcheck_not_locked", aligned, 0);
    align_req = 1'b1;
    step();
    align_req = 1'b0;
    wait_aligned(12, lat);
    chk("midcheck_relock_lat", lat, 6);

    // Stream skewed by 3 bits: offset walks 0..3 and locks on 0F.
    do_reset();
    din = 8'hE1; cur_exp = 8'h0F; en = 1'b1;
    last = offset;
    offs.push_back(last);
    for (int i = 0; i < 40 && aligned !== 1'b1; i++) begin
      step();
      if (offset !== last) begin
        last = offset;
        offs.push_back(last);
      end
    end
    chk("skew_offset_steps", offs.size(), 4);
    for (int i = 0; i < offs.size() && i < 4; i++) chk("skew_offset_seq", offs[i], i);
    chk("skew_locked", aligned, 1);
    chk("skew_offset_final", offset, 3);
    repeat (4) step();

    // One-cycle en drop while locked returns to IDLE, then re-search.
    en = 1'b0;
    step();
    chk("endrop_aligned", aligned, 0);
    chk("endrop_dvalid", dvalid, 0);
    chk("endrop_offset", offset, 0);
    en = 1'b1;
    wait_aligned(40, lat);
    chk("endrop_relock", aligned, 1);
    chk("endrop_relock_offset", offset, 3);
    repeat (3) step();

    // No pattern: every offset tried, then sticky FAIL at offset 7.
    do_reset();
    din = 8'h00; cur_exp = 8'h00; en = 1'b1;
    lat = 0;
    while (lat < 40 && align_fail !== 1'b1) begin
      step();
      lat++;
    end
    chk("nopat_fail", align_fail, 1);
    chk("nopat_offset", offset, 7);
    repeat (3) step();
    chk("nopat_fail_sticky", align_fail, 1);
    chk("nopat_aligned", aligned, 0);
    chk("nopat_dvalid", dvalid, 0);
    din = 8'h0F; cur_exp = 8'h0F; align_req = 1'b1;
    step();
    align_req = 1'b0;
    chk("req_fail_drop", align_fail, 0);
    chk("req_offset_zero", offset, 0);
    wait_aligned(12, lat);
    chk("req_relock", aligned, 1);
    repeat (4) step();

    // Async reset in the middle of SETTLE at a nonzero offset.
    do_reset();
    din = 8'hE1; cur_exp = 8'h0F; en = 1'b1;
    lat = 0;
    while (lat < 30 && offset !== 3'd2) begin
      step();
      lat++;
    end
    chk("midsettle_offset2", offset, 2);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("midsettle_rst");
    sbq.delete();
    step();
    rstn = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
